// File: rtl/fir_guide.sv
// fir_guide: 16-tap symmetric low-pass FIR with pre-add, 8 parallel multipliers and a 4-stage pipeline.
// Define FIR_SIGNED_EN for two's-complement samples and a sign-extended output; the default is unsigned.
module fir_guide_lane #(
  parameter bit          SGN  = 1'b0,
  parameter logic [11:0] COEF = 12'd0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [11:0] xa,
  input  logic [11:0] xb,
  output logic [24:0] prod
);
  logic [12:0] p;

  // Signed mode sign-extends operands. The product is then taken mod 2^25, which is the exact two's-complement result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p    <= '0;
      prod <= '0;
    end else begin
      p    <= {SGN & xa[11], xa} + {SGN & xb[11], xb};
      prod <= {{12{SGN & p[12]}}, p} * {13'd0, COEF};
    end
  end
endmodule

module fir_guide (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [11:0] xin,
  output logic        valid,
  output logic [28:0] yout
);
  localparam int TAPS   = 16;
  localparam int LANES  = TAPS / 2;
  localparam int STAGES = 4;
`ifdef FIR_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  localparam logic [LANES-1:0][11:0] COEF = {12'd255, 12'd235, 12'd198, 12'd152,
                                             12'd104, 12'd63,  12'd31,  12'd11};

  logic [TAPS-1:0][11:0]  x;
  logic [LANES-1:0][24:0] m;
  logic [26:0]            s_a, s_b;
  logic [27:0]            sum;
  logic [STAGES:0]        vld_pipe;

  function automatic logic [26:0] ext27(input logic [24:0] v);
    return {{2{SGN & v[24]}}, v};
  endfunction

  // Only the delay line is gated; later stages run freely and settle on the held window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   x <= '0;
    else if (en) x <= {x[TAPS-2:0], xin};
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      fir_guide_lane #(.SGN(SGN), .COEF(COEF[g])) u_lane (
        .clk  (clk),
        .rstn (rstn),
        .xa   (x[g]),
        .xb   (x[TAPS-1-g]),
        .prod (m[g])
      );
    end
  endgenerate

  assign sum = {SGN & s_a[26], s_a} + {SGN & s_b[26], s_b};

  // vld_pipe[0] marks the sample entering the delay line, and vld_pipe[STAGES] lines up with yout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_a      <= '0;
      s_b      <= '0;
      yout     <= '0;
      vld_pipe <= '0;
    end else begin
      s_a      <= ext27(m[0]) + ext27(m[1]) + ext27(m[2]) + ext27(m[3]);
      s_b      <= ext27(m[4]) + ext27(m[5]) + ext27(m[6]) + ext27(m[7]);
      yout     <= {SGN & sum[27], sum};
      vld_pipe <= {vld_pipe[STAGES-1:0], en};
    end
  end

  assign valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_fir_guide.sv
// tb_fir_guide: directed plus random stimulus, checked every cycle against a convolution model of the filter.
module tb_fir_guide;
  logic        clk = 1'b0, rstn = 1'b0, en = 1'b0;
  logic [11:0] xin = '0;
  logic        valid;
  logic [28:0] yout;

  fir_guide dut (.clk(clk), .rstn(rstn), .en(en), .xin(xin), .valid(valid), .yout(yout));

  always #5 clk = ~clk;

`ifdef FIR_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  typedef struct { logic v; logic [28:0] y; } exp_t;

  int          h[16] = '{11, 31, 63, 104, 152, 198, 235, 255, 255, 235, 198, 152, 104, 63, 31, 11};
  int          hist[16];
  exp_t        q[$];
  int          errors = 0, checks = 0;
  logic [28:0] last_y;
  logic        last_v;

  function automatic int sval(input logic [11:0] v);
    return SGN ? int'($signed(v)) : int'(v);
  endfunction

  function automatic int yval(input logic [28:0] v);
    return SGN ? int'($signed(v)) : int'(v);
  endfunction

  task automatic check(input string tag, input logic [28:0] obs, input logic [28:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  // The output at a given edge reflects the window from four edges earlier, so the queue starts with four zero results.
  task automatic reset_model();
    foreach (hist[i]) hist[i] = 0;
    q.delete();
    repeat (4) q.push_back('{1'b0, 29'd0});
  endtask

  task automatic step(input logic e, input logic [11:0] x, input string tag);
    int   acc;
    exp_t ex;
    en = e; xin = x;
    @(posedge clk);
    if (e) begin
      for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sval(x);
    end
    acc = 0;
    for (int i = 0; i < 16; i++) acc += h[i] * hist[i];
    q.push_back('{e, 29'(acc)});
    @(negedge clk);
    ex = q.pop_front();
    last_y = yout; last_v = valid;
    check({tag, "_valid"}, {28'd0, valid}, {28'd0, ex.v});
    check({tag, "_yout"}, yout, ex.y);
  endtask

  task automatic impulse(input string tag);
    for (int j = 0; j <= 20; j++) begin
      step(1'b1, (j == 0) ? 12'd1 : 12'd0, tag);
      if (j >= 4) begin
        check({tag, "_coef"}, last_y, (j <= 19) ? 29'(h[j-4]) : 29'd0);
        check({tag, "_vhigh"}, {28'd0, last_v}, 29'd1);
      end
    end
  endtask

  initial begin
    int lowcnt, ymin, ymax, xi;
    real pi;
    pi = 3.14159265358979;
    reset_model();
    @(negedge clk);
    check("reset_yout", yout, 29'd0);
    check("reset_valid", {28'd0, valid}, 29'd0);
    rstn = 1'b1;

    impulse("impulse");

    for (int j = 0; j < 30; j++) step(1'b1, 12'd1, "step1");
    check("step_2098", last_y, 29'd2098);
    for (int j = 0; j < 30; j++) step(1'b1, 12'hFFF, "stepmax");
    check("step_max", last_y, SGN ? 29'h1FFFF7CE : 29'd8591310);

    // Three-cycle enable gap: exactly three invalid outputs must show up four edges later.
    lowcnt = 0;
    for (int j = 0; j < 24; j++) begin
      step(!(j >= 8 && j < 11), 12'($urandom_range(0, 4095)), "gate");
      if (!last_v) lowcnt++;
    end
    check("gate_lowcnt", 29'(lowcnt), 29'd3);

    for (int j = 0; j < 120; j++)
      step(($urandom_range(0, 3) != 0), 12'($urandom), "rand");

    // Reset asserted between clock edges must clear the outputs without waiting for a clock edge.
    en = 1'b1; xin = 12'd77;
    #2 rstn = 1'b0;
    #1;
    check("midreset_yout", yout, 29'd0);
    check("midreset_valid", {28'd0, valid}, 29'd0);
    @(negedge clk);
    rstn = 1'b1;
    reset_model();
    impulse("reimpulse");

    ymin = 32'h7fffffff; ymax = -32'h7fffffff;
    for (int n = 0; n < 200; n++) begin
      xi = (SGN ? 0 : 2048) + $rtoi(1000.0 * $sin(2.0 * pi * 0.25 / 50.0 * n))
                            + $rtoi(1000.0 * $sin(2.0 * pi * 7.5 / 50.0 * n));
      step(1'b1, 12'(xi), "band");
      if (n >= 20) begin
        if (yval(last_y) < ymin) ymin = yval(last_y);
        if (yval(last_y) > ymax) ymax = yval(last_y);
      end
    end
    check("band_low_passes", 29'((ymax - ymin) > 1500 * 2098), 29'd1);

    ymin = 32'h7fffffff; ymax = -32'h7fffffff;
    for (int n = 0; n < 100; n++) begin
      xi = (SGN ? 0 : 2048) + $rtoi(1000.0 * $sin(2.0 * pi * 7.5 / 50.0 * n));
      step(1'b1, 12'(xi), "hiband");
      if (n >= 20) begin
        if (yval(last_y) < ymin) ymin = yval(last_y);
        if (yval(last_y) > ymax) ymax = yval(last_y);
      end
    end
    check("band_high_atten", 29'((ymax - ymin) < 200 * 2098), 29'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
